frame_loader: RTL and testbench

- Upstream feeder of the HUB75 panel driver's pixel RAM.
- Accepts a raster-order RGB888 pixel stream and quantises each channel to the driver's 3-bit level (0..6).
- Packs upper-half and lower-half panel pixels into the driver's 18-bit RAM word and writes them via a masked write port.
- Double-buffers the RAM in two banks; swaps banks only at the driver's frame boundary, so the driver never shows a torn frame.

---
 rtl/panel_pkg.sv | 33 +++
 rtl/frame_loader_if.sv | 10 +
 rtl/rgb_quantizer.sv | 16 +
 rtl/frame_loader.sv | 155 +++++++++++++++
 tb/tb_frame_loader.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/panel_pkg.sv
// Shared constants, RAM word layout and loader state type for the HUB75 pixel path.
package panel_pkg;

  localparam int unsigned PANEL_W   = 160;
  localparam int unsigned HALF_ROWS = 20;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned LVL_W     = 3;
  localparam int unsigned LVL_MAX   = 6;

  localparam int unsigned X_W = $clog2(PANEL_W);
  localparam int unsigned Y_W = $clog2(2 * HALF_ROWS);

  localparam int unsigned UPPER_R = 15;
  localparam int unsigned UPPER_G = 12;
  localparam int unsigned UPPER_B = 9;
  localparam int unsigned LOWER_R = 6;
  localparam int unsigned LOWER_G = 3;
  localparam int unsigned LOWER_B = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_SWAP
  } loader_state_t;

  // (c*7)>>8, truncated, maps 0..255 onto 0..LVL_MAX
  function automatic logic [LVL_W-1:0] quantize(input logic [7:0] c);
    logic [15:0] prod;
    prod = 16'(c) * 16'd7;
    return LVL_W'(prod >> 8);
  endfunction

endpackage

// File: rtl/frame_loader_if.sv
// Raster pixel stream handshake into the frame loader.
interface frame_loader_if;
  logic        i_valid;
  logic        o_ready;
  logic        i_sof;
  logic [23:0] i_pixel;

  modport master (output i_valid, output i_sof, output i_pixel, input o_ready);
  modport slave  (input i_valid, input i_sof, input i_pixel, output o_ready);
endinterface

// File: rtl/rgb_quantizer.sv
// Combinational RGB888 -> 3x3-bit level conversion, packed {R,G,B}.
module rgb_quantizer
  import panel_pkg::*;
(
  input  logic [23:0]        i_pixel,
  output logic [3*LVL_W-1:0] o_lvl
);

  always_comb begin
    o_lvl = '0;
    o_lvl[LOWER_R +: LVL_W] = quantize(i_pixel[23:16]);
    o_lvl[LOWER_G +: LVL_W] = quantize(i_pixel[15:8]);
    o_lvl[LOWER_B +: LVL_W] = quantize(i_pixel[7:0]);
  end

endmodule

// File: rtl/frame_loader.sv
// Writes a raster RGB888 stream into the double-buffered HUB75 pixel RAM,
// swapping banks only on the driver's frame-sync pulse.
module frame_loader
  import panel_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  frame_loader_if.slave     pix,
  input  logic              i_frame_sync,
  output logic              o_wr_en,
  output logic [ADDR_W:0]   o_wr_addr,
  output logic [17:0]       o_wr_data,
  output logic [1:0]        o_wr_mask,
  output logic              o_rd_bank,
  output logic              o_frame_err
);

  loader_state_t     state_q, state_d;
  logic [X_W-1:0]    x_q, x_d, cur_x;
  logic [Y_W-1:0]    y_q, y_d, cur_y;
  logic [ADDR_W-1:0] base_q, base_d, cur_base;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              err_q, err_d;
  logic              swapped_q, swapped_d;
  logic              ready_q, ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [17:0]       wr_data_q, wr_data_d;
  logic [1:0]        wr_mask_q, wr_mask_d;
  logic [3*LVL_W-1:0] lvl;
  logic              xfer, do_write;

  rgb_quantizer u_quant (
    .i_pixel (pix.i_pixel),
    .o_lvl   (lvl)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    base_d    = base_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    err_d     = err_q;
    swapped_d = swapped_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_mask_d = wr_mask_q;
    do_write  = 1'b0;
    xfer      = pix.i_valid && ready_q;
    // An SOF pixel is always placed at (0,0), whether starting or restarting
    cur_x     = pix.i_sof ? '0 : x_q;
    cur_y     = pix.i_sof ? '0 : y_q;
    cur_base  = pix.i_sof ? '0 : base_q;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          swapped_d = 1'b0;
          if (pix.i_sof) do_write = 1'b1;
          else if (swapped_q) err_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          do_write = 1'b1;
          if (pix.i_sof && (x_q != '0 || y_q != '0)) err_d = 1'b1;
        end
      end
      ST_WAIT_SWAP: begin
        if (i_frame_sync) begin
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
          x_d       = '0;
          y_d       = '0;
          base_d    = '0;
          swapped_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_write) begin
      wr_en_d   = 1'b1;
      wr_addr_d = {wr_bank_q, cur_base + ADDR_W'(cur_x)};
      wr_mask_d = (cur_y < Y_W'(HALF_ROWS)) ? 2'b10 : 2'b01;
      wr_data_d[UPPER_B +: 3*LVL_W] = lvl;
      wr_data_d[LOWER_B +: 3*LVL_W] = lvl;
      state_d   = ST_LOAD;
      if (cur_x == X_W'(PANEL_W - 1)) begin
        x_d = '0;
        if (cur_y == Y_W'(2 * HALF_ROWS - 1)) begin
          y_d     = '0;
          base_d  = '0;
          state_d = ST_WAIT_SWAP;
        end else begin
          y_d    = cur_y + Y_W'(1);
          // Lower half reuses the same row addresses as the upper half
          base_d = (cur_y == Y_W'(HALF_ROWS - 1)) ? '0 : cur_base + ADDR_W'(PANEL_W);
        end
      end else begin
        x_d    = cur_x + X_W'(1);
        y_d    = cur_y;
        base_d = cur_base;
      end
    end

    ready_d = (state_d != ST_WAIT_SWAP);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      base_q    <= '0;
      wr_bank_q <= 1'b1;
      rd_bank_q <= 1'b0;
      err_q     <= 1'b0;
      swapped_q <= 1'b0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_mask_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      base_q    <= base_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      err_q     <= err_d;
      swapped_q <= swapped_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
    end
  end

  assign pix.o_ready = ready_q;
  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_wr_mask   = wr_mask_q;
  assign o_rd_bank   = rd_bank_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: frame-level reference model plus directed literal checks.
module tb_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_sync = 1'b0;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [17:0] wr_data;
  logic [1:0]  wr_mask;
  logic        rd_bank;
  logic        frame_err;

  frame_loader_if pix ();

  frame_loader dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .pix          (pix),
    .i_frame_sync (frame_sync),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_wr_mask    (wr_mask),
    .o_rd_bank    (rd_bank),
    .o_frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int wcount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lvl(input int c);
    return (c * 7) / 256;
  endfunction

  function automatic logic [23:0] colour(input int n);
    int y;
    y = n / 160;
    return {8'(y * 6), 8'(n % 160), 8'(255 - y * 6)};
  endfunction

  // Reference model: frame progress as a pixel index 0..6399
  bit          m_wait, m_active, m_after_swap, m_wbank, m_rbank, m_err, m_ready, m_xfer;
  int          m_n;
  bit          e_en;
  logic [12:0] e_addr;
  logic [17:0] e_data;
  logic [1:0]  e_mask;

  task automatic emit(input logic [23:0] px);
    int x, y;
    logic [8:0] lv;
    x = m_n % 160;
    y = m_n / 160;
    lv = {3'(lvl(int'(px[23:16]))), 3'(lvl(int'(px[15:8]))), 3'(lvl(int'(px[7:0])))};
    e_en   = 1'b1;
    e_addr = {m_wbank, 12'(x + 160 * (y % 20))};
    e_mask = (y < 20) ? 2'b10 : 2'b01;
    e_data = {lv, lv};
    m_n++;
    if (m_n == 6400) begin
      m_wait   = 1'b1;
      m_active = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_wait = 0; m_active = 0; m_after_swap = 0; m_wbank = 1; m_rbank = 0;
      m_err = 0; m_ready = 0; m_n = 0; e_en = 0; e_addr = '0; e_data = '0; e_mask = '0;
    end else begin
      m_xfer = pix.i_valid && m_ready;
      e_en = 1'b0;
      if (m_wait) begin
        if (frame_sync) begin
          m_rbank = m_wbank;
          m_wbank = ~m_wbank;
          m_wait = 0;
          m_after_swap = 1;
          m_n = 0;
        end
      end else if (m_xfer) begin
        if (pix.i_sof) begin
          if (m_active && m_n != 0) m_err = 1;
          m_n = 0;
          m_active = 1;
          m_after_swap = 0;
          emit(pix.i_pixel);
        end else if (m_active) begin
          emit(pix.i_pixel);
        end else begin
          if (m_after_swap) m_err = 1;
          m_after_swap = 0;
        end
      end
      m_ready = !m_wait;
    end
  end

  initial forever begin
    @(negedge clk);
    check("ready", 32'(pix.o_ready), 32'(m_ready));
    check("wr_en", 32'(wr_en), 32'(e_en));
    check("rd_bank", 32'(rd_bank), 32'(m_rbank));
    check("frame_err", 32'(frame_err), 32'(m_err));
    if (e_en || !rst_n) begin
      check("wr_addr", 32'(wr_addr), 32'(e_addr));
      check("wr_data", 32'(wr_data), 32'(e_data));
      check("wr_mask", 32'(wr_mask), 32'(e_mask));
    end
  end

  initial forever begin
    @(posedge clk);
    if (wr_en) wcount++;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation still running after 60000 cycles, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic sof, input logic [23:0] px, input int gap,
                      input bit noise, input bit sync_with);
    int w;
    for (int i = 0; i < gap; i++) begin
      pix.i_valid = 1'b0;
      pix.i_sof   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      frame_sync  = noise && ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    frame_sync  = sync_with;
    pix.i_valid = 1'b1;
    pix.i_sof   = sof;
    pix.i_pixel = px;
    w = 0;
    while (!pix.o_ready) begin
      @(negedge clk);
      w++;
      if (w > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL ready_wait: o_ready stayed 0 for %0d cycles, expected 1", w);
        break;
      end
    end
    @(negedge clk);
    pix.i_valid = 1'b0;
    pix.i_sof   = 1'b0;
    frame_sync  = 1'b0;
  endtask

  logic [7:0] cval [8] = '{8'd0, 8'd36, 8'd37, 8'd73, 8'd128, 8'd219, 8'd220, 8'd255};
  logic [2:0] lval [8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd3, 3'd5, 3'd6, 3'd6};

  initial begin
    pix.i_valid = 1'b0;
    pix.i_sof   = 1'b0;
    pix.i_pixel = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(pix.o_ready), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_rd_bank", 32'(rd_bank), 32'd0);
    rst_n = 1'b1;

    // Frame 1: back-to-back, bank 1
    push(1'b1, 24'hFF8000, 0, 0, 0);
    check("first_en", 32'(wr_en), 32'd1);
    check("first_addr", 32'(wr_addr), 32'h1000);
    check("first_data", 32'(wr_data), 32'o630630);
    check("first_mask", 32'(wr_mask), 32'd2);
    for (int n = 1; n < 6400; n++) begin
      push(1'b0, colour(n), 0, 0, n == 6399);
      if (n == 3200) begin
        check("row20_addr", 32'(wr_addr), 32'h1000);
        check("row20_mask", 32'(wr_mask), 32'd1);
      end
      if (n == 6399) begin
        check("last_addr", 32'(wr_addr), 32'h1C7F);
        check("last_mask", 32'(wr_mask), 32'd1);
        check("last_ready", 32'(pix.o_ready), 32'd0);
      end
    end
    repeat (3) @(negedge clk);
    check("sync_on_last_ignored", 32'(rd_bank), 32'd0);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    check("swap_rd_bank", 32'(rd_bank), 32'd1);

    // Frame 2: random valid gaps, stray sof/sync noise, bank 0
    wcount = 0;
    for (int n = 0; n < 6400; n++) begin
      push(n == 0, colour(n) ^ 24'h5A5A5A, int'($urandom_range(0, 2)), 1, 0);
      if (n == 0) begin
        check("f2_first_addr", 32'(wr_addr), 32'h0000);
        check("f2_first_mask", 32'(wr_mask), 32'd2);
      end
    end
    repeat (2) @(negedge clk);
    check("f2_write_count", 32'(wcount), 32'd6400);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    check("swap2_rd_bank", 32'(rd_bank), 32'd0);

    // Long frame: sof-less pixel right after a swap
    push(1'b0, 24'h123456, 0, 0, 0);
    check("long_err", 32'(frame_err), 32'd1);
    check("long_no_write", 32'(wr_en), 32'd0);

    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;

    // Quantiser sweep on all channels, then short frame
    for (int i = 0; i < 8; i++) begin
      push(i == 0, {cval[i], cval[i], cval[i]}, 0, 0, 0);
      check("quant_data", 32'(wr_data), 32'({6{lval[i]}}));
    end
    for (int i = 0; i < 8; i++)
      push(1'b0, {cval[i], cval[7 - i], cval[(i + 3) % 8]}, 0, 0, 0);
    for (int n = 16; n < 500; n++) push(1'b0, colour(n), 0, 0, 0);
    check("pre_short_err", 32'(frame_err), 32'd0);
    push(1'b1, 24'h00FF00, 0, 0, 0);
    check("short_err", 32'(frame_err), 32'd1);
    check("short_addr", 32'(wr_addr), 32'h1000);
    check("short_mask", 32'(wr_mask), 32'd2);

    // Reset mid-LOAD at pixel 3000 of the restarted frame
    for (int n = 1; n < 3000; n++) push(1'b0, colour(n), 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(pix.o_ready), 32'd0);
    check("midrst_en", 32'(wr_en), 32'd0);
    check("midrst_addr", 32'(wr_addr), 32'd0);
    check("midrst_data", 32'(wr_data), 32'd0);
    check("midrst_mask", 32'(wr_mask), 32'd0);
    check("midrst_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b1, 24'h00FF00, 0, 0, 0);
    check("post_rst_addr", 32'(wr_addr), 32'h1000);
    check("post_rst_data", 32'(wr_data), 32'o060060);
    check("post_rst_rd_bank", 32'(rd_bank), 32'd0);
    for (int n = 1; n < 4; n++) push(1'b0, colour(n), 0, 0, 0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
